// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
//   PRESCALE_8/16/32 : legal oversampling ratios
//   BIT_CNT_W        : width of the frame bit index (bit_counter)
//   prescale_eff()   : maps any Prescale value to the ratio actually used
package uart_rx_pkg;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;
  localparam int unsigned BIT_CNT_W   = 4;

  // Unsupported ratios fall back to 8 so the edge counter always has a
  // reachable last edge.
  function automatic logic [5:0] prescale_eff(input logic [31:0] prescale);
    if (prescale == PRESCALE_16)      prescale_eff = 6'(PRESCALE_16);
    else if (prescale == PRESCALE_32) prescale_eff = 6'(PRESCALE_32);
    else                              prescale_eff = 6'(PRESCALE_8);
  endfunction

endpackage

// File: rtl/uart_rx_shift_reg.sv
// Data shift register with a saturating capture count.
//   clk, rst   : clock, synchronous active-high reset
//   abort      : clears register and count (receiver left the data phase)
//   clr_cnt    : clears only the count (frame closed)
//   cap        : shift bit_in in at this edge
//   bit_in     : sampled data bit
//   shift      : current shift register contents
//   full       : DATA_WIDTH bits captured since the last clear
module uart_rx_shift_reg #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  abort,
  input  logic                  clr_cnt,
  input  logic                  cap,
  input  logic                  bit_in,
  output logic [DATA_WIDTH-1:0] shift,
  output logic                  full
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] shift_nxt;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    shift_nxt = shift;
    if (LSB_FIRST) shift_nxt = {bit_in, shift[DATA_WIDTH-1:1]};
    else           shift_nxt = {shift[DATA_WIDTH-2:0], bit_in};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together on the edge.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      shift <= '0;
      cnt   <= '0;
    end else if (clr_cnt) begin
      // A capture coinciding with the frame close is dropped.
      cnt <= '0;
    end else if (cap) begin
      shift <= shift_nxt;
      if (cnt != CNT_W'(DATA_WIDTH)) cnt <= cnt + CNT_W'(1);
    end
  end

  assign full = (cnt == CNT_W'(DATA_WIDTH));

endmodule

// File: rtl/uart_rx_deser_param.sv
// UART RX deserializer: captures data bits at the last oversampling edge of
// each bit, loads a holding register on the frame-accept pulse and keeps a
// valid flag until the consumer acknowledges it.
//   CLK, RST     : clock, synchronous active-high reset
//   deser_en     : data/parity phase active; low aborts a partial word
//   sampled_bit  : majority-voted bit
//   Prescale     : oversampling ratio (8/16/32, anything else acts as 8)
//   edge_counter : oversample edge index
//   bit_counter  : frame bit index, 0 = start, 1..DATA_WIDTH = data
//   frame_ok     : frame accepted pulse
//   data_ack     : consumer has taken P_Data
//   P_Data       : holding register
//   P_Valid      : P_Data unread
//   overrun      : pulse, unread word replaced
//   short_frame  : pulse, frame_ok with fewer than DATA_WIDTH bits
// Optional macro UART_DESER_PARITY_EN adds PAR_TYP (0 even, 1 odd) and par_err.
module uart_rx_deser_param
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  deser_en,
  input  logic                  sampled_bit,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic [4:0]            edge_counter,
  input  logic [BIT_CNT_W-1:0]  bit_counter,
  input  logic                  frame_ok,
  input  logic                  data_ack,
  output logic [DATA_WIDTH-1:0] P_Data,
  output logic                  P_Valid,
  output logic                  overrun,
  output logic                  short_frame
`ifdef UART_DESER_PARITY_EN
  ,
  input  logic                  PAR_TYP,
  output logic                  par_err
`endif
);

  logic [4:0]            last_edge;
  logic                  on_edge;
  logic                  in_data;
  logic                  cap;
  logic                  full;
  logic                  load;
  logic [DATA_WIDTH-1:0] shift;

  assign last_edge = 5'(prescale_eff(32'(Prescale)) - 6'd1);
  assign on_edge   = deser_en && (edge_counter == last_edge);
  assign in_data   = (bit_counter != '0) &&
                     (bit_counter <= BIT_CNT_W'(DATA_WIDTH));
  assign cap       = on_edge && in_data;
  assign load      = frame_ok && full;

  uart_rx_shift_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .LSB_FIRST  (LSB_FIRST)
  ) u_shift (
    .clk     (CLK),
    .rst     (RST),
    .abort   (!deser_en),
    .clr_cnt (frame_ok),
    .cap     (cap),
    .bit_in  (sampled_bit),
    .shift   (shift),
    .full    (full)
  );

  // NOTE: the data holding register is reset as well, so P_Data never shows
  // stale or unknown contents after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_Data      <= '0;
      P_Valid     <= 1'b0;
      overrun     <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      overrun     <= 1'b0;
      short_frame <= 1'b0;
      if (load) begin
        P_Data  <= shift;
        P_Valid <= 1'b1;
        // An ack in the load cycle means the old word was consumed.
        overrun <= P_Valid && !data_ack;
      end else begin
        if (frame_ok) short_frame <= 1'b1;
        if (data_ack) P_Valid     <= 1'b0;
      end
    end
  end

`ifdef UART_DESER_PARITY_EN
  logic par_bit;
  logic at_par;

  assign at_par = on_edge && (bit_counter == BIT_CNT_W'(DATA_WIDTH + 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      par_bit <= 1'b0;
      par_err <= 1'b0;
    end else begin
      if (at_par) par_bit <= sampled_bit;
      if (load)          par_err <= ((^shift) ^ par_bit) != PAR_TYP;
      else if (data_ack) par_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Self-checking bench: two DUTs (LSB-first and MSB-first) share stimulus; a
// bit-history model predicts both outputs every cycle, and literal values pin
// the key results.
module tb_uart_rx_deser_param;

  localparam int W = 8;

  logic       CLK = 1'b0;
  logic       RST, deser_en, sampled_bit, frame_ok, data_ack;
  logic [5:0] Prescale;
  logic [4:0] edge_counter;
  logic [3:0] bit_counter;

  logic [W-1:0] p_data_l, p_data_m;
  logic         p_valid_l, p_valid_m, ovr_l, ovr_m, short_l, short_m;
`ifdef UART_DESER_PARITY_EN
  logic par_typ;
  logic par_err_l, par_err_m;
`endif

  always #5 CLK = ~CLK;

  uart_rx_deser_param #(.DATA_WIDTH(W), .LSB_FIRST(1'b1), .PRESCALE_W(6)) dut_lsb (
    .CLK (CLK), .RST (RST), .deser_en (deser_en), .sampled_bit (sampled_bit),
    .Prescale (Prescale), .edge_counter (edge_counter), .bit_counter (bit_counter),
    .frame_ok (frame_ok), .data_ack (data_ack), .P_Data (p_data_l),
    .P_Valid (p_valid_l), .overrun (ovr_l), .short_frame (short_l)
`ifdef UART_DESER_PARITY_EN
    , .PAR_TYP (par_typ), .par_err (par_err_l)
`endif
  );

  uart_rx_deser_param #(.DATA_WIDTH(W), .LSB_FIRST(1'b0), .PRESCALE_W(6)) dut_msb (
    .CLK (CLK), .RST (RST), .deser_en (deser_en), .sampled_bit (sampled_bit),
    .Prescale (Prescale), .edge_counter (edge_counter), .bit_counter (bit_counter),
    .frame_ok (frame_ok), .data_ack (data_ack), .P_Data (p_data_m),
    .P_Valid (p_valid_m), .overrun (ovr_m), .short_frame (short_m)
`ifdef UART_DESER_PARITY_EN
    , .PAR_TYP (par_typ), .par_err (par_err_m)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: bits captured since the last abort/reset, plus the count of
  // captures since the last frame close.
  bit           hist[$];
  int           m_cnt;
  logic         m_valid, m_ovr, m_short, m_perr, m_par_bit;
  logic [W-1:0] m_data_l, m_data_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input int p);
    return (p == 16) ? 16 : (p == 32) ? 32 : 8;
  endfunction

  // Applies one clock edge of the specified behaviour to the model, using
  // the inputs currently driven.
  task automatic model_edge();
    int           last, n;
    bit           cap, load, b;
    logic [W-1:0] wl, wm;
    logic         pe;
    if (RST) begin
      hist.delete();
      m_cnt = 0; m_valid = 0; m_ovr = 0; m_short = 0; m_perr = 0; m_par_bit = 0;
      m_data_l = '0; m_data_m = '0;
      return;
    end
    last = eff(int'(Prescale)) - 1;
    cap  = deser_en && int'(edge_counter) == last &&
           int'(bit_counter) >= 1 && int'(bit_counter) <= W;
    load = frame_ok && m_cnt == W;
    n = hist.size();
    for (int i = 0; i < W; i++) begin
      b = (n - W + i >= 0) ? hist[n - W + i] : 1'b0;
      wl[i]         = b;
      wm[W - 1 - i] = b;
    end
    pe = 1'b0;
`ifdef UART_DESER_PARITY_EN
    pe = ((^wl) ^ m_par_bit) != par_typ;
`endif
    m_ovr   = load && m_valid && !data_ack;
    m_short = frame_ok && !load;
    if (load) begin
      m_data_l = wl; m_data_m = wm; m_valid = 1'b1; m_perr = pe;
    end else if (data_ack) begin
      m_valid = 1'b0; m_perr = 1'b0;
    end
    if (deser_en && int'(edge_counter) == last && int'(bit_counter) == W + 1)
      m_par_bit = sampled_bit;
    if (!deser_en) begin
      hist.delete();
      m_cnt = 0;
    end else if (frame_ok) begin
      m_cnt = 0;
    end else if (cap) begin
      hist.push_back(sampled_bit);
      if (hist.size() > W) void'(hist.pop_front());
      if (m_cnt < W) m_cnt++;
    end
  endtask

  task automatic compare_all();
    check("p_data_lsb",  32'(p_data_l),  32'(m_data_l));
    check("p_data_msb",  32'(p_data_m),  32'(m_data_m));
    check("p_valid_lsb", 32'(p_valid_l), 32'(m_valid));
    check("p_valid_msb", 32'(p_valid_m), 32'(m_valid));
    check("overrun",     32'(ovr_l),     32'(m_ovr));
    check("overrun_msb", 32'(ovr_m),     32'(m_ovr));
    check("short_frame", 32'(short_l),   32'(m_short));
    check("short_msb",   32'(short_m),   32'(m_short));
`ifdef UART_DESER_PARITY_EN
    check("par_err",     32'(par_err_l), 32'(m_perr));
    check("par_err_msb", 32'(par_err_m), 32'(m_perr));
`endif
  endtask

  task automatic step();
    model_edge();
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  // One bit period; the line holds the inverse value except on the intended
  // capture edge, so a capture on any other edge corrupts the word.
  task automatic send_period(input int bc, input logic v);
    int last;
    last = eff(int'(Prescale)) - 1;
    for (int e = 0; e <= last; e++) begin
      edge_counter = 5'(e);
      bit_counter  = 4'(bc);
      sampled_bit  = (e == last) ? v : ~v;
      step();
    end
  endtask

  task automatic send_bits(input logic [W-1:0] d, input int nbits);
    deser_en = 1'b1;
    send_period(0, 1'b0);
    for (int i = 0; i < nbits; i++) send_period(i + 1, d[i]);
  endtask

  task automatic pulse_frame_ok(input logic ack);
    edge_counter = 5'd0;
    frame_ok = 1'b1;
    data_ack = ack;
    step();
    frame_ok = 1'b0;
    data_ack = 1'b0;
  endtask

  task automatic go_idle();
    deser_en = 1'b0; edge_counter = 5'd0; bit_counter = 4'd0; sampled_bit = 1'b1;
  endtask

  // Full frame; returns right after the edge that samples frame_ok.
  task automatic send_frame(input logic [W-1:0] d, input logic par, input logic ack);
    send_bits(d, W);
    send_period(W + 1, par);
    pulse_frame_ok(ack);
    go_idle();
  endtask

  task automatic ack_word();
    data_ack = 1'b1;
    step();
    data_ack = 1'b0;
  endtask

  initial begin
    RST = 1'b1; Prescale = 6'd16; frame_ok = 1'b0; data_ack = 1'b0;
    go_idle();
`ifdef UART_DESER_PARITY_EN
    par_typ = 1'b0;
`endif
    step(); step();
    check("rst_valid", 32'(p_valid_l), 32'd0);
    check("rst_data",  32'(p_data_l),  32'd0);
    RST = 1'b0;
    step();

    // A5 at Prescale 16, visible one cycle after frame_ok.
    send_frame(8'hA5, 1'b0, 1'b0);
    check("a5_lsb",   32'(p_data_l),  32'hA5);
    check("a5_msb",   32'(p_data_m),  32'hA5);
    check("a5_valid", 32'(p_valid_l), 32'd1);
    ack_word();
    check("ack_clears", 32'(p_valid_l), 32'd0);

    send_frame(8'h3C, 1'b0, 1'b0);
    check("3c_lsb", 32'(p_data_l), 32'h3C);
    check("3c_msb", 32'(p_data_m), 32'h3C);

    // Load with a coincident ack while a word is pending: no overrun.
    send_frame(8'h01, 1'b0, 1'b1);
    check("01_lsb",      32'(p_data_l),  32'h01);
    check("01_msb",      32'(p_data_m),  32'h80);
    check("ack_ovr",     32'(ovr_l),     32'd0);
    check("ack_valid",   32'(p_valid_l), 32'd1);
    ack_word();

    // Illegal Prescale behaves as 8.
    Prescale = 6'd5;
    send_frame(8'hA5, 1'b0, 1'b0);
    check("ps5_lsb", 32'(p_data_l), 32'hA5);
    ack_word();
    Prescale = 6'd32;
    send_frame(8'hC3, 1'b0, 1'b0);
    check("ps32_msb", 32'(p_data_m), 32'hC3);
    ack_word();
    Prescale = 6'd16;

    // Overrun.
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    check("ovr_pulse", 32'(ovr_l),    32'd1);
    check("ovr_data",  32'(p_data_l), 32'h22);
    check("ovr_msb",   32'(p_data_m), 32'h44);
    step();
    check("ovr_one_cycle", 32'(ovr_l), 32'd0);
    ack_word();

    // Abort mid-word, then a clean frame.
    send_bits(8'h0F, 4);
    go_idle();
    step();
    send_frame(8'hF0, 1'b0, 1'b0);
    check("abort_f0_lsb", 32'(p_data_l), 32'hF0);
    check("abort_f0_msb", 32'(p_data_m), 32'h0F);

    // Short frame with a word pending: holding register untouched.
    send_bits(8'h0A, 4);
    pulse_frame_ok(1'b0);
    check("short_pulse", 32'(short_l),   32'd1);
    check("short_valid", 32'(p_valid_l), 32'd1);
    check("short_data",  32'(p_data_l),  32'hF0);
    go_idle();
    step();
    check("short_one_cycle", 32'(short_l), 32'd0);
    ack_word();

    // Reset mid-frame with a word pending.
    send_frame(8'h33, 1'b0, 1'b0);
    send_bits(8'h07, 3);
    RST = 1'b1;
    step();
    check("rst_mid_valid", 32'(p_valid_l), 32'd0);
    check("rst_mid_data",  32'(p_data_l),  32'd0);
    RST = 1'b0;
    go_idle();
    step();
    send_frame(8'h5A, 1'b1, 1'b0);
    check("5a_lsb", 32'(p_data_l), 32'h5A);
    check("5a_msb", 32'(p_data_m), 32'h5A);
`ifdef UART_DESER_PARITY_EN
    check("par_err_5a", 32'(par_err_l), 32'd1);
`endif
    ack_word();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser_param.md
Name: uart_rx_deser_param

Overview:
Parametrised, clocked successor to the UART RX deserializer. It shifts sampled data bits into a DATA_WIDTH-bit register at the last oversampling edge of each data bit, in a selectable bit order. On the FSM's frame-accept pulse it loads a holding register and raises a valid flag, held until the consumer acknowledges it, with overrun detection. It sits between data_sampling/edge_bit_counter and the RX FSM and the parallel consumer.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
LSB_FIRST, 1, 1 = first received bit lands in P_Data[0]; 0 = first received bit lands in P_Data[DATA_WIDTH-1].
PRESCALE_W, 6, width of the Prescale input.

Ports:
CLK  in  1  clock.
RST  in  1  synchronous, active-high reset.
deser_en  in  1  FSM is in the data/parity phase; low aborts any partial word.
sampled_bit  in  1  majority-voted bit from data_sampling.
Prescale  in  PRESCALE_W  oversampling ratio; legal values 8/16/32; any other value is treated as 8.
edge_counter  in  5  oversample edge index, 0..Prescale_eff-1.
bit_counter  in  4  bit index in frame: 0 = start, 1..DATA_WIDTH = data bits.
frame_ok  in  1  one-cycle pulse from FSM when stop (and parity, if enabled) checks pass.
data_ack  in  1  consumer has taken P_Data.
P_Data  out  DATA_WIDTH  holding register.
P_Valid  out  1  P_Data holds an unread word.
overrun  out  1  one-cycle pulse: a new word replaced an unread word.
short_frame  out  1  one-cycle pulse: frame_ok arrived with fewer than DATA_WIDTH bits captured.

Behaviour:
- Reset (RST=1 at a CLK edge): shift register, capture count, P_Data, P_Valid, overrun and short_frame all go to 0.
- Capture strobe, cap = deser_en && edge_counter == Prescale_eff-1 && 1 <= bit_counter <= DATA_WIDTH.
- On cap:
  - LSB_FIRST=1: shift <= {sampled_bit, shift[W-1:1]}.
  - LSB_FIRST=0: shift <= {shift[W-2:0], sampled_bit}.
  - cnt <= cnt+1, saturating at DATA_WIDTH.
- Two captures can never occur in consecutive cycles unless edge_counter does so. The block does not rely on bit_counter order, only on the count of captures.
- deser_en=0: cnt <= 0 and shift <= 0 on the next edge. P_Data and P_Valid are unaffected. This is the abort / mid-frame break path.
- frame_ok with cnt==DATA_WIDTH:
  - Next edge: P_Data <= shift, P_Valid <= 1, cnt <= 0.
  - Latency: P_Data/P_Valid are visible one cycle after frame_ok.
- frame_ok with cnt<DATA_WIDTH: short_frame pulses for 1 cycle, cnt <= 0, P_Data and P_Valid unchanged.
- data_ack while P_Valid=1 and no load in the same cycle: P_Valid <= 0 next edge. data_ack while P_Valid=0 is ignored.
- Load while P_Valid=1:
  - If data_ack is also high: new word loads, P_Valid stays 1, no overrun.
  - Otherwise: new word overwrites P_Data, P_Valid stays 1, overrun pulses 1 cycle.
- frame_ok and cap in the same cycle is a protocol error. frame_ok has priority, and the cap bit is discarded.
- Outputs are registered. There is no combinational path from any input to any output.

Optional Feature:
Macro: UART_DESER_PARITY_EN.
With the macro defined:
- Extra input PAR_TYP (0 = even, 1 = odd) and extra output par_err.
- The bit at bit_counter==DATA_WIDTH+1 is captured, on the same edge condition, into par_bit.
- On a load, par_err <= (^shift ^ par_bit) != PAR_TYP. It is registered alongside P_Data and cleared on data_ack and on RST.
- The data is still loaded when par_err=1.
Without the macro: the ports are absent, and bit_counter > DATA_WIDTH never captures.

Decomposition:
- Shared package uart_rx_pkg holds:
  - prescale localparams PRESCALE_8/16/32;
  - the function prescale_eff(), which maps an illegal Prescale to 8;
  - the bit_counter width constant BIT_CNT_W=4.
- One sub-module, uart_rx_shift_reg: the DATA_WIDTH shift register with capture count, parametrised by LSB_FIRST. The top-level module holds the holding register and the handshake.

Test Plan:
- W=8, LSB_FIRST=1, Prescale=16; send bits 1,0,1,0,0,1,0,1 captured at edge 15 each, then frame_ok -> P_Data=8'hA5 and P_Valid=1 one cycle after frame_ok.
- Same bits with LSB_FIRST=0 -> P_Data=8'hA5 reversed = 8'hA5; repeat with 8'h3C stream (LSB first 0,0,1,1,1,1,0,0) -> 8'h3C (LSB_FIRST=1), 8'h3C bit-reversed = 8'h3C; use 8'h01 -> 8'h80 for LSB_FIRST=0.
- Prescale=5 (illegal): captures occur at edge 7 only; edge 4 is ignored -> behaves as Prescale=8.
- Word 8'h11 loaded, no ack, word 8'h22 loaded -> overrun pulses 1 cycle, P_Data=8'h22. Repeat with data_ack coincident with the load -> overrun=0, P_Valid stays 1.
- 4 bits captured, deser_en drops, then a full 8-bit frame of 8'hF0 -> P_Data=8'hF0. 4 bits captured then frame_ok -> short_frame pulses and P_Valid is unchanged.
- RST asserted mid-frame after 3 captures with P_Valid=1 -> all outputs 0 next edge. A following frame of 8'h5A loads correctly. With UART_DESER_PARITY_EN, even parity, data 8'h5A with parity bit 1 -> par_err=1.
